uart_fifo_bridge: RTL

// - Parametrised, buffered byte bridge between the LC3 core's UART registers and the host-side

---
 rtl/uart_fifo_bridge.sv | 101 ++++++++++
 1 files changed

// File: rtl/uart_fifo_bridge.sv
// uart_fifo_bridge: buffered TX (core->host) and RX (host->core) byte FIFOs with occupancy outputs.
// Defining UART_LOOPBACK_EN adds a loopback port that routes the TX head straight into the RX FIFO.
module uart_fifo_bridge_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH = 16,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] pushData,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [LVL_W-1:0]  level
);
    localparam int PTR_W = $clog2(DEPTH);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr, rdPtr;
    always_ff @(posedge clk) if (push) mem[wrPtr] <= pushData;
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop) rdPtr <= rdPtr + 1'b1;
            level <= level + LVL_W'(push) - LVL_W'(pop);
        end
    end
    assign head = (level != '0) ? mem[rdPtr] : '0;
endmodule

module uart_fifo_bridge #(
    parameter int DATA_W = 8,
    parameter int DEPTH = 16,
    parameter int DROP_ON_FULL = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_W-1:0]            core_tx_data,
    input  logic                         core_tx_valid,
    output logic                         core_tx_ready,
    output logic [DATA_W-1:0]            core_rx_data,
    output logic                         core_rx_valid,
    input  logic                         core_rx_ready,
    output logic [DATA_W-1:0]            host_tx_data,
    output logic                         host_tx_valid,
    input  logic                         host_tx_ready,
    input  logic [DATA_W-1:0]            host_rx_data,
    input  logic                         host_rx_valid,
    output logic                         host_rx_ready,
    output logic [$clog2(DEPTH+1)-1:0]   tx_level,
    output logic [$clog2(DEPTH+1)-1:0]   rx_level,
    output logic                         rx_overflow,
    input  logic                         overflow_clr
`ifdef UART_LOOPBACK_EN
    ,
    input  logic                         loopback
`endif
);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam logic [LVL_W-1:0] FULL = LVL_W'(DEPTH);
    logic lb, txFull, rxFull, txPush, txPop, rxPush, rxPop, move, drop, overflowFlag;
    logic [DATA_W-1:0] rxPushData;
`ifdef UART_LOOPBACK_EN
    assign lb = loopback;
`else
    assign lb = 1'b0;
`endif
    // Readiness comes only from registered levels, so a full FIFO refuses a push even while popping.
    always_comb begin
        txFull = tx_level == FULL;
        rxFull = rx_level == FULL;
        core_tx_ready = !txFull;
        core_rx_valid = rx_level != '0;
        host_tx_valid = !lb && tx_level != '0;
        host_rx_ready = !lb && (DROP_ON_FULL != 0 || !rxFull);
        move = lb && tx_level != '0 && !rxFull;
        txPush = core_tx_valid && core_tx_ready;
        txPop = (host_tx_valid && host_tx_ready) || move;
        rxPush = (host_rx_valid && host_rx_ready && !rxFull) || move;
        rxPushData = move ? host_tx_data : host_rx_data;
        rxPop = core_rx_valid && core_rx_ready;
        drop = DROP_ON_FULL != 0 && !lb && host_rx_valid && rxFull;
        rx_overflow = overflowFlag;
    end
    always_ff @(posedge clk) begin
        if (reset) overflowFlag <= 1'b0;
        else if (drop) overflowFlag <= 1'b1;
        else if (overflow_clr) overflowFlag <= 1'b0;
    end
    uart_fifo_bridge_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LVL_W(LVL_W)) txFifo (
        .clk(clk), .reset(reset), .push(txPush), .pushData(core_tx_data),
        .pop(txPop), .head(host_tx_data), .level(tx_level)
    );
    uart_fifo_bridge_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LVL_W(LVL_W)) rxFifo (
        .clk(clk), .reset(reset), .push(rxPush), .pushData(rxPushData),
        .pop(rxPop), .head(core_rx_data), .level(rx_level)
    );
endmodule
